// File: rtl/stage_sequencer.sv
// Multi-cycle instruction stage sequencer: walks IF/ID/EXE/MEM/WB per opcode class,
// traps on illegal opcodes or a stalled memory access, and counts retired instructions.
module stage_sequencer #(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    input  logic             enable_i,
    input  logic [6:0]       opcode_i,
    input  logic             zero_i,
    input  logic             mem_ready_i,
    output logic             state_if_o,
    output logic             state_id_o,
    output logic             state_exe_o,
    output logic             state_mem_o,
    output logic             state_wb_o,
    output logic             ir_we_o,
    output logic             pc_we_o,
    output logic             pc_src_o,
    output logic             reg_we_o,
    output logic             mem_re_o,
    output logic             mem_we_o,
    output logic             fault_o,
    output logic [CNT_W-1:0] retired_o
);
    // state  | meaning
    // S_IF   | fetch: load instruction register
    // S_ID   | decode: latch opcode class, trap on illegal opcode
    // S_EXE  | execute: branches finish here
    // S_MEM  | data access, waits for mem_ready with timeout
    // S_WB   | register write-back and PC update
    // S_TRAP | sticky fault, left only by reset
    typedef enum logic [2:0] {S_IF, S_ID, S_EXE, S_MEM, S_WB, S_TRAP} state_t;
    typedef enum logic [2:0] {C_NONE, C_R, C_I, C_LOAD, C_STORE, C_BRANCH} cls_t;

    localparam int TW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

    state_t            state_q, state_d;
    cls_t              cls_q, cls_d, opc_cls;
    logic [TW-1:0]     wait_q, wait_d;
    logic [CNT_W-1:0]  retired_q, retired_d;
    logic              adv;

    always_comb begin
        case (opcode_i)
            7'b0110011: opc_cls = C_R;
            7'b0010011: opc_cls = C_I;
            7'b0000011: opc_cls = C_LOAD;
            7'b0100011: opc_cls = C_STORE;
            7'b1100011: opc_cls = C_BRANCH;
            default:    opc_cls = C_NONE;
        endcase
    end

    // Reset is folded in so enables drop the instant reset asserts.
    assign adv = enable_i & reset_n_i;

    always_comb begin
        state_d   = state_q;
        cls_d     = cls_q;
        wait_d    = wait_q;
        ir_we_o   = 1'b0;
        pc_we_o   = 1'b0;
        pc_src_o  = 1'b0;
        reg_we_o  = 1'b0;
        mem_re_o  = 1'b0;
        mem_we_o  = 1'b0;
        fault_o   = 1'b0;
        case (state_q)
            S_IF: begin
                ir_we_o = adv;
                if (adv) state_d = S_ID;
            end
            S_ID: begin
                if (adv) begin
                    cls_d   = opc_cls;
                    state_d = (opc_cls == C_NONE) ? S_TRAP : S_EXE;
                end
            end
            S_EXE: begin
                case (cls_q)
                    C_BRANCH: begin
                        pc_src_o = zero_i;
                        pc_we_o  = adv;
                        if (adv) state_d = S_IF;
                    end
                    C_LOAD, C_STORE: begin
                        if (adv) begin
                            state_d = S_MEM;
                            wait_d  = '0;
                        end
                    end
                    C_R, C_I: begin
                        if (adv) state_d = S_WB;
                    end
                    default: begin
                        if (adv) state_d = S_TRAP;
                    end
                endcase
            end
            S_MEM: begin
                mem_re_o = adv && (cls_q == C_LOAD);
                mem_we_o = adv && (cls_q == C_STORE);
                if (adv) begin
                    if (cls_q != C_LOAD && cls_q != C_STORE) begin
                        state_d = S_TRAP;
                    end else if (mem_ready_i) begin
                        if (cls_q == C_LOAD) begin
                            state_d = S_WB;
                        end else begin
                            pc_we_o = 1'b1;
                            state_d = S_IF;
                        end
                    end else if (wait_q == TW'(MEM_TIMEOUT)) begin
                        state_d = S_TRAP;
                    end else begin
                        wait_d = wait_q + TW'(1);
                    end
                end
            end
            S_WB: begin
                reg_we_o = adv;
                pc_we_o  = adv;
                if (adv) state_d = S_IF;
            end
            S_TRAP: begin
                fault_o = 1'b1;
            end
            default: begin
                state_d = S_TRAP;
            end
        endcase
        retired_d = pc_we_o ? retired_q + CNT_W'(1) : retired_q;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q   <= S_IF;
            cls_q     <= C_NONE;
            wait_q    <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            cls_q     <= cls_d;
            wait_q    <= wait_d;
            retired_q <= retired_d;
        end
    end

    assign state_if_o  = (state_q == S_IF);
    assign state_id_o  = (state_q == S_ID);
    assign state_exe_o = (state_q == S_EXE);
    assign state_mem_o = (state_q == S_MEM);
    assign state_wb_o  = (state_q == S_WB);
    assign retired_o   = retired_q;
endmodule
